// File: rtl/autoconfig_dram_ctrl.sv
// Zorro II autoconfig responder plus CBR-refresh DRAM controller for Amiga FastRAM
// expansions. Offer size, board IDs, refresh rate and DRAM geometry are parameters.
module autoconfig_dram_ctrl #(
    parameter int          MAX_LOG2_MB      = 3,
    parameter int          MIN_LOG2_MB      = 0,
    parameter logic [15:0] MFG_ID           = 16'h07DB,
    parameter logic [7:0]  PROD_ID          = 8'd70,
    parameter logic [15:0] SERIAL           = 16'd421,
    parameter int          REFRESH_INTERVAL = 109,
    parameter int          ROW_BITS         = 12,
    parameter int          COL_BITS         = 10
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                CFGINn,
    input  logic                ASn,
    input  logic                UDSn,
    input  logic                LDSn,
    input  logic                RWn,
    input  logic [23:1]         ADDR,
    input  logic [3:0]          DBUS_IN,
    output logic [3:0]          DBUS_OUT,
    output logic                DBUS_OE,
    output logic [ROW_BITS-1:0] MADDR,
    output logic                CFGOUTn,
    output logic                RASn,
    output logic                UCASn,
    output logic                LCASn,
    output logic                OEn,
    output logic                MEMWn,
    output logic                REFRESH_OVF
);
    localparam int TMR_W = $clog2(REFRESH_INTERVAL);

    typedef enum logic [1:0] {AC_OFFER, AC_DONE, AC_SHUTUP} ac_state_t;
    typedef enum logic [2:0] {D_IDLE, D_ROW, D_COL, D_HOLD, D_PRE,
                              D_RF_CAS, D_RF_RAS, D_RF_PRE} dram_state_t;

    logic [4:0]       bus_p0, bus_p1;
    logic             as_p2, uds_p2;
    logic             as_s, uds_s, lds_s, rw_s, cfgin_s;
    ac_state_t        ac_state;
    dram_state_t      dram_state;
    logic [1:0]       size_log2;
    logic [3:0]       base;
    logic             configured;
    logic             active, hit, tmr_wrap, rf_done;
    logic [4:0]       bank, lo, hi;
    logic [TMR_W-1:0] rf_timer;
    logic [2:0]       debt;

    function automatic logic [3:0] size_code(input logic [1:0] s);
        case (s)
            2'd3:    return 4'h0;
            2'd2:    return 4'h7;
            2'd1:    return 4'h6;
            default: return 4'h5;
        endcase
    endfunction

    function automatic logic [3:0] cfg_nibble(input logic [6:0] r, input logic [1:0] s);
        case (r)
            7'h00:        return 4'hE;
            7'h01:        return size_code(s);
            7'h02:        return ~PROD_ID[7:4];
            7'h03:        return ~PROD_ID[3:0];
            7'h04:        return ~4'd8;
            7'h05:        return ~4'd0;
            7'h08:        return ~MFG_ID[15:12];
            7'h09:        return ~MFG_ID[11:8];
            7'h0A:        return ~MFG_ID[7:4];
            7'h0B:        return ~MFG_ID[3:0];
            7'h10:        return ~SERIAL[15:12];
            7'h11:        return ~SERIAL[11:8];
            7'h12:        return ~SERIAL[7:4];
            7'h13:        return ~SERIAL[3:0];
            7'h20, 7'h21: return 4'h0;
            default:      return 4'hF;
        endcase
    endfunction

    function automatic logic [2:0] debt_sat_inc(input logic [2:0] d);
        return (d == 3'd7) ? 3'd7 : d + 3'd1;
    endfunction

    // p0/p1: two-flop synchronisers; p2: previous synchronised value for edge detection
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bus_p0 <= '1;
            bus_p1 <= '1;
            as_p2  <= 1'b1;
            uds_p2 <= 1'b1;
        end else begin
            bus_p0 <= {ASn, UDSn, LDSn, RWn, CFGINn};
            bus_p1 <= bus_p0;
            as_p2  <= bus_p1[4];
            uds_p2 <= bus_p1[3];
        end
    end

    assign {as_s, uds_s, lds_s, rw_s, cfgin_s} = bus_p1;
    assign active = (ADDR[23:16] == 8'hE8) && !cfgin_s && (ac_state == AC_OFFER);

    // Bounds are 5 bits wide so base + size cannot wrap past bank F
    assign bank = {1'b0, ADDR[23:20]};
    assign lo   = {1'b0, base};
    assign hi   = lo + (5'd1 << size_log2);
    assign hit  = configured && (bank >= lo) && (bank < hi) && (bank >= 5'd2) && (bank <= 5'd9);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ac_state   <= AC_OFFER;
            size_log2  <= 2'(MAX_LOG2_MB);
            base       <= 4'h0;
            configured <= 1'b0;
            CFGOUTn    <= 1'b1;
            DBUS_OE    <= 1'b0;
            DBUS_OUT   <= 4'hF;
        end else begin
            DBUS_OE  <= active && rw_s && !as_s && !uds_s;
            DBUS_OUT <= active ? cfg_nibble(ADDR[7:1], size_log2) : 4'hF;
            if (active && !rw_s && !as_s && uds_p2 && !uds_s) begin
                if (ADDR[7:1] == 7'h26) begin
                    if (size_log2 > 2'(MIN_LOG2_MB))
                        size_log2 <= size_log2 - 2'd1;
                    else
                        ac_state <= AC_SHUTUP;
                end else if (ADDR[7:1] == 7'h24) begin
                    base       <= DBUS_IN;
                    configured <= 1'b1;
                    ac_state   <= AC_DONE;
                end
            end
            if (!as_p2 && as_s)
                CFGOUTn <= (ac_state == AC_OFFER);
        end
    end

    assign tmr_wrap = (rf_timer == TMR_W'(REFRESH_INTERVAL - 1));
    assign rf_done  = (dram_state == D_RF_PRE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rf_timer    <= '0;
            debt        <= 3'd0;
            REFRESH_OVF <= 1'b0;
        end else begin
            rf_timer <= tmr_wrap ? '0 : rf_timer + 1'b1;
            if (tmr_wrap && !rf_done) begin
                debt <= debt_sat_inc(debt);
                if (debt_sat_inc(debt) == 3'd7)
                    REFRESH_OVF <= 1'b1;
            end else if (!tmr_wrap && rf_done) begin
                debt <= debt - 3'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            dram_state <= D_IDLE;
            MADDR      <= '0;
            RASn       <= 1'b1;
            UCASn      <= 1'b1;
            LCASn      <= 1'b1;
            OEn        <= 1'b1;
            MEMWn      <= 1'b1;
        end else begin
            OEn   <= !(dram_state inside {D_ROW, D_COL, D_HOLD}) || as_s || (uds_s && lds_s);
            MEMWn <= rw_s || (uds_s && lds_s) || (dram_state == D_IDLE);
            case (dram_state)
                D_IDLE: begin
                    MADDR <= ADDR[COL_BITS+ROW_BITS:COL_BITS+1];
                    if (!as_s && hit) begin
                        dram_state <= D_ROW;
                        RASn       <= 1'b0;
                    end else if (as_s && debt != 3'd0) begin
                        dram_state <= D_RF_CAS;
                        UCASn      <= 1'b0;
                        LCASn      <= 1'b0;
                    end
                end
                D_ROW: begin
                    dram_state <= D_COL;
                    MADDR      <= ROW_BITS'(ADDR[COL_BITS:1]);
                    UCASn      <= uds_s;
                    LCASn      <= lds_s;
                end
                D_COL: begin
                    if (as_s) begin
                        dram_state <= D_PRE;
                        {RASn, UCASn, LCASn} <= 3'b111;
                    end else begin
                        UCASn <= uds_s;
                        LCASn <= lds_s;
                        if (!UCASn || !LCASn)
                            dram_state <= D_HOLD;
                    end
                end
                D_HOLD: begin
                    if (as_s) begin
                        dram_state <= D_PRE;
                        {RASn, UCASn, LCASn} <= 3'b111;
                    end
                end
                D_PRE:    dram_state <= D_IDLE;
                D_RF_CAS: begin
                    dram_state <= D_RF_RAS;
                    RASn       <= 1'b0;
                end
                D_RF_RAS: begin
                    dram_state <= D_RF_PRE;
                    {RASn, UCASn, LCASn} <= 3'b111;
                end
                D_RF_PRE: dram_state <= D_IDLE;
                default:  dram_state <= D_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_autoconfig_dram_ctrl.sv
// Bench for autoconfig_dram_ctrl: table-driven autoconfig reads through a
// scoreboard queue, plus hand-written DRAM access and refresh sequences.
`timescale 1ns/1ps
module tb_autoconfig_dram_ctrl;
    localparam int RI = 109;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        CFGINn = 1'b0;
    logic        ASn = 1'b1, UDSn = 1'b1, LDSn = 1'b1, RWn = 1'b1;
    logic [23:1] ADDR = '0;
    logic [3:0]  DBUS_IN = '0;
    logic [3:0]  DBUS_OUT;
    logic        DBUS_OE;
    logic [11:0] MADDR;
    logic        CFGOUTn, RASn, UCASn, LCASn, OEn, MEMWn, REFRESH_OVF;

    int checks = 0;
    int failures = 0;
    logic [3:0] exp_q[$];

    typedef struct {
        logic [6:0] rg;
        logic [3:0] nib;
    } rd_vec_t;
    rd_vec_t rd_tab[17];

    logic        m_acc, m_col_ok, m_ras_after;
    logic [11:0] m_row, m_col;
    logic [4:0]  m_end;

    autoconfig_dram_ctrl dut (
        .CLK(CLK), .RESET(RESET), .CFGINn(CFGINn),
        .ASn(ASn), .UDSn(UDSn), .LDSn(LDSn), .RWn(RWn),
        .ADDR(ADDR), .DBUS_IN(DBUS_IN), .DBUS_OUT(DBUS_OUT), .DBUS_OE(DBUS_OE),
        .MADDR(MADDR), .CFGOUTn(CFGOUTn),
        .RASn(RASn), .UCASn(UCASn), .LCASn(LCASn), .OEn(OEn), .MEMWn(MEMWn),
        .REFRESH_OVF(REFRESH_OVF)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1; ASn = 1'b1; UDSn = 1'b1; LDSn = 1'b1; RWn = 1'b1; CFGINn = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic cfg_read(input logic [6:0] rg, input logic exp_oe, input logic [3:0] nib,
                            input string name);
        logic [23:0] ba;
        logic        seen;
        logic [3:0]  e;
        ba = 24'hE80000 | {16'h0, rg, 1'b0};
        if (exp_oe) exp_q.push_back(nib);
        @(negedge CLK);
        ADDR = ba[23:1]; RWn = 1'b1; ASn = 1'b0; UDSn = 1'b0; LDSn = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge CLK);
            if (DBUS_OE && !seen) begin
                seen = 1'b1;
                if (exp_oe) begin
                    e = exp_q.pop_front();
                    check(name, DBUS_OUT, e);
                end
            end
        end
        check({name, "_oe"}, seen, exp_oe);
        if (exp_oe && !seen) void'(exp_q.pop_front());
        ASn = 1'b1; UDSn = 1'b1; LDSn = 1'b1;
        repeat (4) @(negedge CLK);
        check({name, "_oe_off"}, DBUS_OE, 1'b0);
    endtask

    task automatic cfg_write(input logic [6:0] rg, input logic [3:0] data);
        logic [23:0] ba;
        ba = 24'hE80000 | {16'h0, rg, 1'b0};
        @(negedge CLK);
        ADDR = ba[23:1]; RWn = 1'b0; DBUS_IN = data; ASn = 1'b0; UDSn = 1'b0; LDSn = 1'b0;
        repeat (6) @(negedge CLK);
        ASn = 1'b1; UDSn = 1'b1; LDSn = 1'b1; RWn = 1'b1;
        repeat (4) @(negedge CLK);
    endtask

    task automatic mem_cycle(input logic [23:0] ba, input logic rw, input logic uds, input logic lds);
        logic prev;
        @(negedge CLK);
        ADDR = ba[23:1]; RWn = rw; UDSn = uds; LDSn = lds; ASn = 1'b0;
        m_acc = 1'b0; m_col_ok = 1'b0; m_row = '0; m_col = '0;
        prev = RASn;
        repeat (12) begin
            @(negedge CLK);
            if (prev && !RASn && UCASn && LCASn) begin
                m_acc = 1'b1;
                m_row = MADDR;
            end
            if (m_acc && !m_col_ok && !RASn && (!UCASn || !LCASn)) begin
                m_col_ok = 1'b1;
                m_col = MADDR;
            end
            prev = RASn;
        end
        m_end = {RASn, UCASn, LCASn, OEn, MEMWn};
        ASn = 1'b1; UDSn = 1'b1; LDSn = 1'b1; RWn = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        m_ras_after = RASn;
        repeat (4) @(negedge CLK);
    endtask

    task automatic expect_hit(input logic [23:0] ba, input logic rw, input logic uds,
                              input logic lds, input string name);
        mem_cycle(ba, rw, uds, lds);
        check({name, "_ras"}, m_acc, 1'b1);
        check({name, "_row"}, m_row, ba[22:11]);
        check({name, "_col"}, m_col, {2'b00, ba[10:1]});
        check({name, "_strobes"}, m_end, {1'b0, uds, lds, 1'b0, rw});
        check({name, "_ras_release"}, m_ras_after, 1'b1);
    endtask

    task automatic expect_miss(input logic [23:0] ba, input string name);
        mem_cycle(ba, 1'b1, 1'b0, 1'b0);
        check({name, "_no_ras"}, m_acc, 1'b0);
    endtask

    initial begin
        int  ras_falls, cbr;
        logic prev, cut;

        rd_tab[0]  = '{7'h00, 4'hE};  rd_tab[1]  = '{7'h01, 4'h0};
        rd_tab[2]  = '{7'h02, 4'hB};  rd_tab[3]  = '{7'h03, 4'h9};
        rd_tab[4]  = '{7'h04, 4'h7};  rd_tab[5]  = '{7'h05, 4'hF};
        rd_tab[6]  = '{7'h06, 4'hF};  rd_tab[7]  = '{7'h08, 4'hF};
        rd_tab[8]  = '{7'h09, 4'h8};  rd_tab[9]  = '{7'h0A, 4'h2};
        rd_tab[10] = '{7'h0B, 4'h4};  rd_tab[11] = '{7'h10, 4'hF};
        rd_tab[12] = '{7'h11, 4'hE};  rd_tab[13] = '{7'h12, 4'h5};
        rd_tab[14] = '{7'h13, 4'hA};  rd_tab[15] = '{7'h20, 4'h0};
        rd_tab[16] = '{7'h21, 4'h0};

        repeat (2) @(negedge CLK);
        check("rst_strobes", {RASn, UCASn, LCASn, OEn, MEMWn}, 5'h1F);
        check("rst_cfgout", CFGOUTn, 1'b1);
        check("rst_dbus_oe", DBUS_OE, 1'b0);
        check("rst_dbus_out", DBUS_OUT, 4'hF);
        check("rst_maddr", MADDR, 12'h000);
        check("rst_ovf", REFRESH_OVF, 1'b0);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);

        for (int i = 0; i < 17; i++)
            cfg_read(rd_tab[i].rg, 1'b1, rd_tab[i].nib, $sformatf("rd_reg%02h", rd_tab[i].rg));

        CFGINn = 1'b1;
        cfg_read(7'h00, 1'b0, 4'h0, "rd_cfgin_high");
        CFGINn = 1'b0;

        cfg_write(7'h26, 4'h0);
        cfg_read(7'h01, 1'b1, 4'h7, "rd_size_4m");
        cfg_write(7'h26, 4'h0);
        cfg_read(7'h01, 1'b1, 4'h6, "rd_size_2m");
        cfg_write(7'h26, 4'h0);
        cfg_read(7'h01, 1'b1, 4'h5, "rd_size_1m");
        check("cfgout_offer", CFGOUTn, 1'b1);
        cfg_write(7'h26, 4'h0);
        check("cfgout_shutup", CFGOUTn, 1'b0);
        cfg_read(7'h00, 1'b0, 4'h0, "rd_after_shutup");

        do_reset();
        cfg_write(7'h24, 4'h2);
        check("cfgout_done", CFGOUTn, 1'b0);
        cfg_read(7'h00, 1'b0, 4'h0, "rd_after_config");
        expect_hit(24'h200000, 1'b1, 1'b0, 1'b0, "m8_200000");
        expect_hit(24'h9FFFFE, 1'b1, 1'b0, 1'b0, "m8_9ffffe");
        expect_miss(24'hA00000, "m8_a00000");
        expect_miss(24'h100000, "m8_100000");

        do_reset();
        cfg_write(7'h26, 4'h0);
        cfg_write(7'h24, 4'h6);
        expect_miss(24'h5FFFFE, "b6_5ffffe");
        expect_hit(24'h600000, 1'b1, 1'b0, 1'b0, "b6_600000");
        expect_hit(24'h9FFFFE, 1'b1, 1'b0, 1'b0, "b6_9ffffe");
        expect_miss(24'hA00000, "b6_a00000");

        do_reset();
        cfg_write(7'h26, 4'h0);
        cfg_write(7'h24, 4'h8);
        expect_miss(24'h7FFFFE, "b8_7ffffe");
        expect_hit(24'h800000, 1'b1, 1'b0, 1'b0, "b8_800000");
        expect_hit(24'h9FFFFE, 1'b1, 1'b0, 1'b0, "b8_9ffffe");
        expect_miss(24'hA00000, "b8_a00000");
        expect_hit(24'h800002, 1'b0, 1'b1, 1'b0, "b8_lds_write");

        // Refresh debt builds while ASn is held low, then drains back to back
        @(negedge CLK);
        RESET = 1'b1; ADDR = '0; RWn = 1'b1; UDSn = 1'b1; LDSn = 1'b1; ASn = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        ras_falls = 0; prev = RASn;
        repeat (8 * RI + 20) begin
            @(negedge CLK);
            if (prev && !RASn) ras_falls++;
            prev = RASn;
        end
        check("hold_no_refresh", ras_falls, 0);
        check("ovf_set", REFRESH_OVF, 1'b1);
        ASn = 1'b1; cbr = 0;
        repeat (60) begin
            @(negedge CLK);
            if (prev && !RASn && !UCASn && !LCASn) cbr++;
            prev = RASn;
        end
        check("cbr_count", cbr, 7);
        check("ovf_sticky", REFRESH_OVF, 1'b1);

        @(negedge CLK);
        RESET = 1'b1; ASn = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        prev = RASn;
        repeat (8 * RI + 20) @(negedge CLK);
        ASn = 1'b1; cbr = 0; cut = 1'b0;
        repeat (40) begin
            @(negedge CLK);
            if (prev && !RASn && !UCASn && !LCASn) cbr++;
            prev = RASn;
            if (!cut && cbr == 3 && !RASn) begin
                cut = 1'b1;
                RESET = 1'b1;
                #1;
                check("midrf_rst_strobes", {RASn, UCASn, LCASn, OEn, MEMWn}, 5'h1F);
                check("midrf_rst_ovf", REFRESH_OVF, 1'b0);
                check("midrf_rst_maddr", MADDR, 12'h000);
            end
        end
        check("midrf_reached_third", cut, 1'b1);
        @(negedge CLK);
        RESET = 1'b0;
        repeat (4) @(negedge CLK);
        check("post_rst_cfgout", CFGOUTn, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
